// File: rtl/pa_idu_pkg.sv
// pa_idu_pkg -- definitions shared by the IDU register scoreboard slice.
//   sb_state_e : occupancy state of the producer queue (IDLE / PARTIAL / FULL)
//   id_w()     : width of an ID/count field able to hold n distinct values
//                (never less than 1 bit)
package pa_idu_pkg;

  typedef enum logic [1:0] {
    SB_IDLE    = 2'b00,
    SB_PARTIAL = 2'b01,
    SB_FULL    = 2'b10
  } sb_state_e;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pa_idu_reg_wsel.sv
// pa_idu_reg_wsel -- register write-select mux and data flop.
//   forever_cpuclk  in  clock
//   write_en        in  per-port data-write strobe (lowest index wins)
//   write_data      in  per-port data, port p at [p*DATA_W +: DATA_W]
//   warm_up         in  forces a port-0 write when no write_en is set
//   dout_fwd        out combinational bypass of the value being written
//   dout            out registered register value (no reset: pure data flop)
module pa_idu_reg_wsel
  import pa_idu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WPORTS = 3
) (
  input  logic                     forever_cpuclk,
  input  logic [WPORTS-1:0]        write_en,
  input  logic [WPORTS*DATA_W-1:0] write_data,
  input  logic                     warm_up,
  output logic [DATA_W-1:0]        dout_fwd,
  output logic [DATA_W-1:0]        dout
);

  logic [DATA_W-1:0] wsel_s;
  logic              wr_any_s;
  logic [DATA_W-1:0] dout_r;

  // Priority select: scan from the top so the lowest asserted port lands last.
  always_comb begin
    if (warm_up) begin
      wsel_s = write_data[DATA_W-1:0];
    end else begin
      wsel_s = dout_r;
    end
    for (int p = WPORTS - 1; p >= 0; p--) begin
      if (write_en[p]) begin
        wsel_s = write_data[p*DATA_W +: DATA_W];
      end else begin
        wsel_s = wsel_s;
      end
    end
  end

  assign wr_any_s = (|write_en) | warm_up;

  // Data flop: loads the selected value on any write, otherwise holds.
  always_ff @(posedge forever_cpuclk) begin
    if (wr_any_s) begin
      dout_r <= wsel_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign dout_fwd = wsel_s;
  assign dout     = dout_r;

endmodule

// File: rtl/pa_idu_reg_sb.sv
// pa_idu_reg_sb -- register value holder plus outstanding-producer scoreboard.
//   forever_cpuclk in  clock
//   cpurst         in  synchronous active-high reset
//   issue_vld      in  a producer targeting this register issues
//   issue_port     in  write port that producer will use
//   fwd_en         in  per-port producer-complete (retire) strobe
//   write_en       in  per-port data-write strobe
//   write_data     in  per-port write data
//   warm_up        in  forces a port-0 data write
//   flush          in  front-end flush, empties the producer queue
//   dout_fwd       out combinational bypass value
//   dout           out registered value
//   busy           out one or more producers outstanding
//   busy_port      out port of the oldest outstanding producer (0 when idle)
//   full           out DEPTH producers outstanding
//   cnt            out outstanding producer count
// Build option: PA_IDU_REG_SB_OOO_RETIRE_EN -- when defined, each asserted
// fwd_en[p] retires the oldest entry on port p (several per cycle); otherwise
// only the queue head may retire, one per cycle.
module pa_idu_reg_sb
  import pa_idu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int WPORTS = 3,
  parameter  int DEPTH  = 2,
  localparam int PW     = id_w(WPORTS),
  localparam int CW     = id_w(DEPTH + 1)
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     issue_vld,
  input  logic [PW-1:0]            issue_port,
  input  logic [WPORTS-1:0]        fwd_en,
  input  logic [WPORTS-1:0]        write_en,
  input  logic [WPORTS*DATA_W-1:0] write_data,
  input  logic                     warm_up,
  input  logic                     flush,
  output logic [DATA_W-1:0]        dout_fwd,
  output logic [DATA_W-1:0]        dout,
  output logic                     busy,
  output logic [PW-1:0]            busy_port,
  output logic                     full,
  output logic [CW-1:0]            cnt
);

  // Data path lives in its own block; the queue below never touches dout.
  pa_idu_reg_wsel #(
    .DATA_W (DATA_W),
    .WPORTS (WPORTS)
  ) u_wsel (
    .forever_cpuclk (forever_cpuclk),
    .write_en       (write_en),
    .write_data     (write_data),
    .warm_up        (warm_up),
    .dout_fwd       (dout_fwd),
    .dout           (dout)
  );

  // Queue entries beyond cnt are always kept at zero.
  logic [PW-1:0] q_r       [DEPTH];
  logic [PW-1:0] q_ret_s   [DEPTH];
  logic [PW-1:0] q_nxt_s   [DEPTH];
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_ret_s;
  logic [CW-1:0] cnt_nxt_s;
  sb_state_e     state_r;
  logic [PW-1:0] busy_port_r;

  function automatic logic port_hit(input logic [WPORTS-1:0] en,
                                    input logic [PW-1:0]     port);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      if (en[p] && (port == PW'(p))) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

`ifdef PA_IDU_REG_SB_OOO_RETIRE_EN
  logic [WPORTS-1:0] taken_s;
  logic [DEPTH-1:0]  kill_s;
  int                wr_s;

  // Out-of-order retire: each strobed port kills its oldest entry, survivors
  // are packed toward entry 0 keeping their relative age.
  always_comb begin
    taken_s = {WPORTS{1'b0}};
    kill_s  = {DEPTH{1'b0}};
    wr_s    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      q_ret_s[i] = {PW{1'b0}};
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int p = 0; p < WPORTS; p++) begin
        if ((CW'(i) < cnt_r) && fwd_en[p] && !taken_s[p] && !kill_s[i] &&
            (q_r[i] == PW'(p))) begin
          kill_s[i]  = 1'b1;
          taken_s[p] = 1'b1;
        end else begin
          kill_s[i]  = kill_s[i];
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_r) && !kill_s[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (wr_s == j) begin
            q_ret_s[j] = q_r[i];
          end else begin
            q_ret_s[j] = q_ret_s[j];
          end
        end
        wr_s = wr_s + 1;
      end else begin
        wr_s = wr_s;
      end
    end
    cnt_ret_s = CW'(wr_s);
  end
`else
  logic retire_s;

  // In-order retire: only the head may leave, and only on its own port.
  always_comb begin
    retire_s  = (cnt_r != {CW{1'b0}}) && port_hit(fwd_en, q_r[0]);
    cnt_ret_s = cnt_r;
    for (int i = 0; i < DEPTH; i++) begin
      q_ret_s[i] = {PW{1'b0}};
    end
    if (retire_s) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_ret_s[i] = q_r[i+1];
      end
      cnt_ret_s = cnt_r - CW'(1'b1);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_ret_s[i] = q_r[i];
      end
      cnt_ret_s = cnt_r;
    end
  end
`endif

  // Issue appends behind the survivors; a slot freed this cycle makes room
  // when full. Flush discards everything including same-cycle issue/retire.
  always_comb begin
    cnt_nxt_s = cnt_ret_s;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt_s[i] = q_ret_s[i];
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_nxt_s[i] = {PW{1'b0}};
      end
      cnt_nxt_s = {CW{1'b0}};
    end else if (issue_vld && (cnt_ret_s < CW'(DEPTH))) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CW'(j) == cnt_ret_s) begin
          q_nxt_s[j] = issue_port;
        end else begin
          q_nxt_s[j] = q_nxt_s[j];
        end
      end
      cnt_nxt_s = cnt_ret_s + CW'(1'b1);
    end else begin
      cnt_nxt_s = cnt_ret_s;
    end
  end

  // Queue state machine with registered status outputs.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_r     <= SB_IDLE;
      cnt_r       <= {CW{1'b0}};
      busy_port_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= {PW{1'b0}};
      end
    end else begin
      cnt_r       <= cnt_nxt_s;
      busy_port_r <= q_nxt_s[0];
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= q_nxt_s[i];
      end
      if (cnt_nxt_s == {CW{1'b0}}) begin
        state_r <= SB_IDLE;
      end else if (cnt_nxt_s == CW'(DEPTH)) begin
        state_r <= SB_FULL;
      end else begin
        state_r <= SB_PARTIAL;
      end
    end
  end

  assign busy      = (state_r != SB_IDLE);
  assign full      = (state_r == SB_FULL);
  assign busy_port = busy_port_r;
  assign cnt       = cnt_r;

endmodule

// File: tb/tb_pa_idu_reg_sb.sv
// tb_pa_idu_reg_sb -- directed bench for pa_idu_reg_sb (default parameters).
// Data path checked from a vector table; queue behaviour from short sequences.
// Expectations follow PA_IDU_REG_SB_OOO_RETIRE_EN where the retire mode matters.
module tb_pa_idu_reg_sb;

  logic        clk;
  logic        cpurst;
  logic        issue_vld;
  logic [1:0]  issue_port;
  logic [2:0]  fwd_en;
  logic [2:0]  write_en;
  logic [95:0] write_data;
  logic        warm_up;
  logic        flush;
  logic [31:0] dout_fwd;
  logic [31:0] dout;
  logic        busy;
  logic [1:0]  busy_port;
  logic        full;
  logic [1:0]  cnt;

  int n_cmp;
  int n_err;

  pa_idu_reg_sb dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .issue_vld      (issue_vld),
    .issue_port     (issue_port),
    .fwd_en         (fwd_en),
    .write_en       (write_en),
    .write_data     (write_data),
    .warm_up        (warm_up),
    .flush          (flush),
    .dout_fwd       (dout_fwd),
    .dout           (dout),
    .busy           (busy),
    .busy_port      (busy_port),
    .full           (full),
    .cnt            (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  we;
    logic        wu;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One queue cycle: drive controls, clock, release strobes.
  task automatic qcyc(input logic iv, input logic [1:0] ip, input logic [2:0] fe, input logic fl);
    issue_vld  = iv;
    issue_port = ip;
    fwd_en     = fe;
    flush      = fl;
    tick();
    issue_vld  = 1'b0;
    issue_port = 2'd0;
    fwd_en     = 3'b000;
    flush      = 1'b0;
  endtask

  task automatic chk_q(input string name, input logic [1:0] ec, input logic eb,
                       input logic ef, input logic [1:0] ep);
    chk({name, ".cnt"},       {30'd0, cnt},       {30'd0, ec});
    chk({name, ".busy"},      {31'd0, busy},      {31'd0, eb});
    chk({name, ".full"},      {31'd0, full},      {31'd0, ef});
    chk({name, ".busy_port"}, {30'd0, busy_port}, {30'd0, ep});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] last_dout;
    n_cmp = 0;
    n_err = 0;

    tbl[0] = '{we: 3'b001, wu: 1'b0, d0: 32'h0000_00A0, d1: 32'h0000_00A1, d2: 32'h0000_00A2, exp: 32'h0000_00A0};
    tbl[1] = '{we: 3'b110, wu: 1'b0, d0: 32'h0000_00FF, d1: 32'h0000_0011, d2: 32'h0000_0022, exp: 32'h0000_0011};
    tbl[2] = '{we: 3'b000, wu: 1'b0, d0: 32'h1234_5678, d1: 32'h9ABC_DEF0, d2: 32'h0BAD_F00D, exp: 32'h0000_0011};
    tbl[3] = '{we: 3'b000, wu: 1'b1, d0: 32'h0000_0055, d1: 32'h0000_0033, d2: 32'h0000_0044, exp: 32'h0000_0055};
    tbl[4] = '{we: 3'b100, wu: 1'b1, d0: 32'h0000_0066, d1: 32'h0000_0088, d2: 32'h0000_0077, exp: 32'h0000_0077};
    tbl[5] = '{we: 3'b111, wu: 1'b0, d0: 32'hCAFE_0001, d1: 32'hCAFE_0002, d2: 32'hCAFE_0003, exp: 32'hCAFE_0001};
    tbl[6] = '{we: 3'b010, wu: 1'b0, d0: 32'h1111_1111, d1: 32'hDEAD_BEEF, d2: 32'h2222_2222, exp: 32'hDEAD_BEEF};
    tbl[7] = '{we: 3'b000, wu: 1'b0, d0: 32'h3333_3333, d1: 32'h4444_4444, d2: 32'h5555_5555, exp: 32'hDEAD_BEEF};

    cpurst     = 1'b1;
    issue_vld  = 1'b0;
    issue_port = 2'd0;
    fwd_en     = 3'b000;
    write_en   = 3'b000;
    write_data = 96'd0;
    warm_up    = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    cpurst = 1'b0;
    chk_q("reset", 2'd0, 1'b0, 1'b0, 2'd0);

    // Data path vectors: bypass same cycle, registered value next cycle.
    for (int v = 0; v < 8; v++) begin
      write_en   = tbl[v].we;
      warm_up    = tbl[v].wu;
      write_data = {tbl[v].d2, tbl[v].d1, tbl[v].d0};
      #1;
      chk($sformatf("vec%0d.dout_fwd", v), dout_fwd, tbl[v].exp);
      tick();
      write_en = 3'b000;
      warm_up  = 1'b0;
      chk($sformatf("vec%0d.dout", v), dout, tbl[v].exp);
    end
    last_dout = tbl[7].exp;

    // Issue 2 then 1, retire on the non-head port, then the head port.
    qcyc(1'b1, 2'd2, 3'b000, 1'b0);
    chk_q("iss2", 2'd1, 1'b1, 1'b0, 2'd2);
    qcyc(1'b1, 2'd1, 3'b000, 1'b0);
    chk_q("iss1", 2'd2, 1'b1, 1'b1, 2'd2);
    qcyc(1'b1, 2'd0, 3'b000, 1'b0);
    chk_q("full_drop", 2'd2, 1'b1, 1'b1, 2'd2);
    qcyc(1'b0, 2'd0, 3'b010, 1'b0);
`ifdef PA_IDU_REG_SB_OOO_RETIRE_EN
    chk_q("ret_p1", 2'd1, 1'b1, 1'b0, 2'd2);
    qcyc(1'b0, 2'd0, 3'b100, 1'b0);
    chk_q("ret_p2", 2'd0, 1'b0, 1'b0, 2'd0);
`else
    chk_q("ret_p1", 2'd2, 1'b1, 1'b1, 2'd2);
    qcyc(1'b0, 2'd0, 3'b100, 1'b0);
    chk_q("ret_p2", 2'd1, 1'b1, 1'b0, 2'd1);
`endif
    qcyc(1'b0, 2'd0, 3'b010, 1'b0);
    chk_q("drain", 2'd0, 1'b0, 1'b0, 2'd0);

    // Full queue: issue and head retire together keep it full.
    qcyc(1'b1, 2'd2, 3'b000, 1'b0);
    qcyc(1'b1, 2'd1, 3'b000, 1'b0);
    chk_q("refill", 2'd2, 1'b1, 1'b1, 2'd2);
    qcyc(1'b1, 2'd0, 3'b100, 1'b0);
    chk_q("iss_ret", 2'd2, 1'b1, 1'b1, 2'd1);
    qcyc(1'b0, 2'd0, 3'b010, 1'b0);
    chk_q("entry1", 2'd1, 1'b1, 1'b0, 2'd0);
    qcyc(1'b0, 2'd0, 3'b001, 1'b0);
    chk_q("empty", 2'd0, 1'b0, 1'b0, 2'd0);

    // Flush wins over same-cycle issue and retire.
    qcyc(1'b1, 2'd0, 3'b000, 1'b0);
    qcyc(1'b1, 2'd2, 3'b000, 1'b0);
    chk_q("pre_flush", 2'd2, 1'b1, 1'b1, 2'd0);
    qcyc(1'b1, 2'd1, 3'b001, 1'b1);
    chk_q("flush", 2'd0, 1'b0, 1'b0, 2'd0);
    chk("flush.dout", dout, last_dout);

    // Reset mid-queue clears the queue but leaves dout alone.
    qcyc(1'b1, 2'd1, 3'b000, 1'b0);
    chk_q("pre_rst", 2'd1, 1'b1, 1'b0, 2'd1);
    cpurst = 1'b1;
    qcyc(1'b1, 2'd2, 3'b000, 1'b0);
    cpurst = 1'b0;
    chk_q("mid_rst", 2'd0, 1'b0, 1'b0, 2'd0);
    chk("mid_rst.dout", dout, last_dout);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pa_idu_reg_sb.md
PA_IDU_REG_SB -- requirements
Module: pa_idu_reg_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the register value.
REQ-002 SHALL have parameter WPORTS, default 3: number of write/forward ports.
REQ-003 SHALL have parameter DEPTH, default 2: maximum number of outstanding producers tracked.
REQ-004 SHALL have one clock and a synchronous active-high reset; ports: forever_cpuclk in 1 clock; cpurst in 1 reset.
REQ-005 SHALL have issue_vld in 1: a producer targeting this register issues this cycle.
REQ-006 SHALL have issue_port in clog2(WPORTS): the write port that producer will use.
REQ-007 SHALL have fwd_en in WPORTS: per-port producer-complete (retire) strobe.
REQ-008 SHALL have write_en in WPORTS: per-port data-write strobe.
REQ-009 SHALL have write_data in WPORTS*DATA_W: per-port write data, with port p in slice [p*DATA_W +: DATA_W].
REQ-010 SHALL have warm_up in 1: forces a port-0 data write.
REQ-011 SHALL have flush in 1: front-end flush.
REQ-012 SHALL have dout_fwd out DATA_W: combinational bypass value.
REQ-013 SHALL have dout out DATA_W: registered value.
REQ-014 SHALL have busy out 1: one or more producers outstanding.
REQ-015 SHALL have busy_port out clog2(WPORTS): port of the oldest outstanding producer.
REQ-016 SHALL have full out 1: DEPTH producers outstanding.
REQ-017 SHALL have cnt out clog2(DEPTH+1): outstanding producer count.

Function
REQ-018 SHALL select write data combinationally: the lowest asserted write_en index wins; else port 0 if warm_up; else dout; the result drives dout_fwd.
REQ-019 SHALL load dout from dout_fwd on the next clock edge when any write_en or warm_up is asserted, and otherwise hold dout.
REQ-020 SHALL track outstanding producers as an age-ordered queue of port IDs (entries 0..cnt-1, entry 0 oldest); the queue state machine is IDLE (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
REQ-021 SHALL, on retire (in-order mode), remove entry 0 when fwd_en[entry0.port] is asserted; fwd_en on any other port is ignored.
REQ-022 SHALL, on issue, append issue_port at position cnt minus the number of entries retired this cycle.
REQ-023 SHALL accept an issue when full if a retire occurs in the same cycle; an issue when full with no retire is dropped and cnt is unchanged.
REQ-024 SHALL, when flush is asserted, clear the queue next cycle to cnt=0; a simultaneous issue or retire is discarded; dout is unaffected.
REQ-025 SHALL drive busy=(cnt!=0), full=(cnt==DEPTH), and busy_port=entry0.port (0 when idle), all as registered outputs.
REQ-026 SHALL keep cnt within 0..DEPTH under all stimulus, with no wrap-around.

Reset
REQ-027 SHALL, on cpurst, set cnt=0, busy=0, full=0, busy_port=0 and all queue entries to 0.
REQ-028 SHALL NOT reset dout (data flop without reset); reset SHALL take priority over flush, issue and retire.

Configuration
REQ-029 SHALL, when PA_IDU_REG_SB_OOO_RETIRE_EN is defined, retire for each asserted fwd_en[p] the oldest entry whose port is p, allowing multiple retires per cycle; remaining entries SHALL be compacted with age order preserved.
REQ-030 SHALL, when PA_IDU_REG_SB_OOO_RETIRE_EN is undefined, retire in order per REQ-021, at most one entry per cycle.

Structure
REQ-031 SHALL place the state encodings (IDLE/PARTIAL/FULL) and the port-ID width function in shared package pa_idu_pkg.
REQ-032 SHALL implement the data path (write-select mux plus dout flop) as sub-module pa_idu_reg_wsel; the scoreboard queue SHALL be inline.

Verification
REQ-033 SHALL cover: write_en=3'b110 with data1=0x11, data2=0x22 -> dout_fwd=0x11 same cycle, dout=0x11 next cycle.
REQ-034 SHALL cover: issue port 2, then issue port 1 (DEPTH=2) -> cnt=2, full=1, busy_port=2; fwd_en=3'b010 in in-order mode -> cnt stays 2.
REQ-035 SHALL cover: the same sequence with PA_IDU_REG_SB_OOO_RETIRE_EN defined -> cnt=1, busy_port=2; then fwd_en=3'b100 -> cnt=0, busy=0.
REQ-036 SHALL cover: full, with issue port 0 and fwd_en for the head port in the same cycle -> cnt stays 2, busy_port=the former entry 1, entry 1=0.
REQ-037 SHALL cover: cnt=2 with flush and issue_vld together -> next cycle cnt=0, busy=0, full=0.
REQ-038 SHALL cover: cpurst asserted mid-queue (cnt=1) -> next cycle cnt=0, busy_port=0; dout retains its pre-reset value.
